// File: rtl/quant_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// quant_engine: 3-stage INT8 -> 4-bit quantizer. Optional saturation counter
// is built when QUANT_STATS_EN is defined.    Revision: 1.0
// ---------------------------------------------------------------------------
module quant_engine #(
  parameter int LANES = 16,
  parameter int ACC_W = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*8-1:0]   in_data,
  input  logic                 in_last,
  input  logic [15:0]          inv_scale_q8_8,
  input  logic [7:0]           zero_point,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*4-1:0]   out_data,
  output logic                 out_last
`ifdef QUANT_STATS_EN
  ,
  output logic [15:0]          sat_count,
  input  logic                 stats_clr
`endif
);

  logic advance;

  logic                    s1_valid, s1_last;
  logic [7:0]              s1_zp;
  logic signed [23:0]      s1_prod [LANES];

  logic                    s2_valid, s2_last;
  logic signed [ACC_W-1:0] s2_r [LANES];

  logic signed [23:0]      prod_c [LANES];
  logic signed [ACC_W-1:0] r_c [LANES];
  logic [3:0]              q_c [LANES];
  logic [LANES-1:0]        sat_c;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [23:0] a, b, rnd;
    logic sat_lo, sat_hi;

    assign a         = {{16{in_data[i*8+7]}}, in_data[i*8 +: 8]};
    assign b         = {{8{inv_scale_q8_8[15]}}, inv_scale_q8_8};
    assign prod_c[i] = a * b;

    // +128 before the arithmetic shift rounds half toward +inf
    assign rnd    = s1_prod[i] + 24'sd128;
    assign r_c[i] = {{(ACC_W-16){rnd[23]}}, rnd[23:8]}
                  + {{(ACC_W-8){s1_zp[7]}}, s1_zp};

    assign sat_lo   = s2_r[i][ACC_W-1];
    assign sat_hi   = ~s2_r[i][ACC_W-1] & (|s2_r[i][ACC_W-2:4]);
    assign q_c[i]   = sat_lo ? 4'd0 : (sat_hi ? 4'd15 : s2_r[i][3:0]);
    assign sat_c[i] = sat_lo | sat_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_zp     <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_prod[i] <= '0;
        s2_r[i]    <= '0;
      end
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_last   <= in_last;
      s1_zp     <= zero_point;
      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      out_valid <= s2_valid;
      out_last  <= s2_last;
      for (int i = 0; i < LANES; i++) begin
        s1_prod[i]         <= prod_c[i];
        s2_r[i]            <= r_c[i];
        out_data[i*4 +: 4] <= q_c[i];
      end
    end
  end

`ifdef QUANT_STATS_EN
  localparam int CNT_W = $clog2(LANES + 1);
  logic [CNT_W-1:0] sat_lanes;
  logic [16:0]      sat_sum;

  always_comb begin
    sat_lanes = '0;
    for (int i = 0; i < LANES; i++) sat_lanes = sat_lanes + CNT_W'(sat_c[i]);
  end

  assign sat_sum = {1'b0, sat_count} + 17'(sat_lanes);

  always_ff @(posedge clk) begin
    if (rst || stats_clr)
      sat_count <= '0;
    else if (advance && s2_valid)
      sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end
`else
  logic unused_sat;
  assign unused_sat = ^sat_c;
`endif

endmodule
`default_nettype wire
